// File: rtl/pic_pkg.sv
// Shared encodings for the 8259 programming-interface master: command opcodes,
// ICW/OCW bit positions, FSM and bus-phase state types, and register formatters.
package pic_pkg;

    localparam logic [2:0] OP_OCW1   = 3'd0;
    localparam logic [2:0] OP_OCW2   = 3'd1;
    localparam logic [2:0] OP_OCW3   = 3'd2;
    localparam logic [2:0] OP_RD_IRR = 3'd3;
    localparam logic [2:0] OP_RD_ISR = 3'd4;
    localparam logic [2:0] OP_RD_IMR = 3'd5;

    localparam logic [7:0] OCW3_RD_IRR = 8'h0A;
    localparam logic [7:0] OCW3_RD_ISR = 8'h0B;

    localparam int unsigned ICW1_IC4  = 32'd0;
    localparam int unsigned ICW1_SNGL = 32'd1;
    localparam int unsigned ICW1_D4   = 32'd4;
    localparam int unsigned OCW3_RIS  = 32'd0;
    localparam int unsigned OCW3_RR   = 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ICW1     = 3'd1,
        ST_ICW2     = 3'd2,
        ST_ICW3     = 3'd3,
        ST_ICW4     = 3'd4,
        ST_PRE_OCW3 = 3'd5,
        ST_MAIN     = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_SETUP   = 3'd1,
        PH_STROBE  = 3'd2,
        PH_HOLD    = 3'd3,
        PH_RECOVER = 3'd4
    } phase_e;

    typedef enum logic {
        SEL_IRR = 1'b0,
        SEL_ISR = 1'b1
    } rd_sel_e;

    function automatic logic [7:0] icw1_fmt(input logic [7:0] d);
        logic [7:0] r;
        r = d;
        r[ICW1_D4] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] ocw2_fmt(input logic [7:0] d);
        return {d[7:5], 2'b00, d[2:0]};
    endfunction

    function automatic logic [7:0] ocw3_fmt(input logic [7:0] d);
        return {1'b0, d[6:5], 2'b01, d[2:0]};
    endfunction

    function automatic logic is_read_op(input logic [2:0] op);
        return (op == OP_RD_IRR) || (op == OP_RD_ISR) || (op == OP_RD_IMR);
    endfunction

endpackage

// File: rtl/pic_bus_master_if.sv
// Command port toward the CPU side plus the pin-level bus toward the 8259.
interface pic_bus_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       CS_n;
    logic       WR_n;
    logic       RD_n;
    logic       A0;
    logic [7:0] dout;
    logic       dout_oe;
    logic [7:0] din;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, din,
        output cmd_ready, rd_data, rd_valid, CS_n, WR_n, RD_n, A0, dout, dout_oe
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, din,
        input  cmd_ready, rd_data, rd_valid, CS_n, WR_n, RD_n, A0, dout, dout_oe
    );
endinterface

// File: rtl/pic_bus_cycle.sv
// One 8259 read or write bus cycle: SETUP, STROBE, HOLD, RECOVER with registered pins.
// A new request may start on the last RECOVER clock so that cycles run back to back.
module pic_bus_cycle import pic_pkg::*; #(
    parameter int unsigned T_SETUP   = 32'd1,
    parameter int unsigned T_STROBE  = 32'd2,
    parameter int unsigned T_HOLD    = 32'd1,
    parameter int unsigned T_RECOVER = 32'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       is_read,
    input  logic       a0,
    input  logic [7:0] wdata,
    input  logic [7:0] din,
    output logic       done,
    output logic [7:0] rdata,
    output logic       bus_cs_n,
    output logic       bus_wr_n,
    output logic       bus_rd_n,
    output logic       bus_a0,
    output logic [7:0] bus_dout,
    output logic       bus_oe
);
    localparam logic [2:0] SETUP_LAST   = 3'(T_SETUP - 32'd1);
    localparam logic [2:0] STROBE_LAST  = 3'(T_STROBE - 32'd1);
    localparam logic [2:0] HOLD_LAST    = 3'(T_HOLD - 32'd1);
    localparam logic [2:0] RECOVER_LAST = 3'(T_RECOVER - 32'd1);

    phase_e     phase_r;
    logic [2:0] cnt_r;
    logic       cs_n_r, wr_n_r, rd_n_r, a0_r, oe_r, read_r;
    logic [7:0] dout_r, rdata_r;
    logic       done_s, start_s;

    assign done_s  = (phase_r == PH_RECOVER) && (cnt_r == RECOVER_LAST);
    assign start_s = req && ((phase_r == PH_IDLE) || done_s);

    assign done     = done_s;
    assign rdata    = rdata_r;
    assign bus_cs_n = cs_n_r;
    assign bus_wr_n = wr_n_r;
    assign bus_rd_n = rd_n_r;
    assign bus_a0   = a0_r;
    assign bus_dout = dout_r;
    assign bus_oe   = oe_r;

    // Phase sequencer and pin registers
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r <= PH_IDLE;
            cnt_r   <= 3'd0;
            cs_n_r  <= 1'b1;
            wr_n_r  <= 1'b1;
            rd_n_r  <= 1'b1;
            a0_r    <= 1'b0;
            oe_r    <= 1'b0;
            read_r  <= 1'b0;
            dout_r  <= 8'h00;
            rdata_r <= 8'h00;
        end else if (start_s) begin
            phase_r <= PH_SETUP;
            cnt_r   <= 3'd0;
            cs_n_r  <= 1'b0;
            wr_n_r  <= 1'b1;
            rd_n_r  <= 1'b1;
            a0_r    <= a0;
            oe_r    <= ~is_read;
            read_r  <= is_read;
            dout_r  <= is_read ? 8'h00 : wdata;
        end else begin
            case (phase_r)
                PH_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        phase_r <= PH_STROBE;
                        cnt_r   <= 3'd0;
                        wr_n_r  <= read_r;
                        rd_n_r  <= ~read_r;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                PH_STROBE: begin
                    if (cnt_r == STROBE_LAST) begin
                        phase_r <= PH_HOLD;
                        cnt_r   <= 3'd0;
                        wr_n_r  <= 1'b1;
                        rd_n_r  <= 1'b1;
                        if (read_r) begin
                            rdata_r <= din;
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                PH_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        phase_r <= PH_RECOVER;
                        cnt_r   <= 3'd0;
                        cs_n_r  <= 1'b1;
                        oe_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                PH_RECOVER: begin
                    if (done_s) begin
                        phase_r <= PH_IDLE;
                        cnt_r   <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                default: begin
                    phase_r <= PH_IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end
endmodule

// File: rtl/pic_bus_master.sv
// CPU-side 8259 initiator: ICW1..ICW4 initialisation, then a single-entry command port
// for OCW writes and IRR/ISR/IMR reads with automatic OCW3 read-select insertion.
module pic_bus_master import pic_pkg::*; #(
    parameter int unsigned T_SETUP   = 32'd1,
    parameter int unsigned T_STROBE  = 32'd2,
    parameter int unsigned T_HOLD    = 32'd1,
    parameter int unsigned T_RECOVER = 32'd2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_init,
    input  logic [7:0]              icw1_cfg,
    input  logic [7:0]              icw2_cfg,
    input  logic [7:0]              icw3_cfg,
    input  logic [7:0]              icw4_cfg,
    output logic                    init_done,
    output logic                    busy,
    pic_bus_master_if.master        bus
);
    state_e     state_r;
    rd_sel_e    rd_sel_r;
    logic       init_done_r, busy_r, rd_valid_r, sngl_r, ic4_r;
    logic [7:0] rd_data_r, icw2_r, icw3_r, icw4_r;
    logic [2:0] op_r;
    logic       req_s, is_read_s, a0_s, cyc_done_s, accept_s, cmd_ready_s;
    logic [7:0] wdata_s, rdata_s;

    // start_init wins a same-cycle tie with a pending command
    assign cmd_ready_s   = (state_r == ST_IDLE) && init_done_r && !start_init;
    assign accept_s      = cmd_ready_s && bus.cmd_valid;
    assign bus.cmd_ready = cmd_ready_s;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign init_done     = init_done_r;
    assign busy          = busy_r;

    // Bus request decode: issues the next cycle on the edge the state advances
    always_comb begin
        req_s     = 1'b0;
        is_read_s = 1'b0;
        a0_s      = 1'b0;
        wdata_s   = 8'h00;
        case (state_r)
            ST_IDLE: begin
                if (start_init) begin
                    req_s   = 1'b1;
                    wdata_s = icw1_fmt(icw1_cfg);
                end else if (accept_s) begin
                    case (bus.cmd_op)
                        OP_OCW1: begin req_s = 1'b1; a0_s = 1'b1; wdata_s = bus.cmd_data; end
                        OP_OCW2: begin req_s = 1'b1; wdata_s = ocw2_fmt(bus.cmd_data); end
                        OP_OCW3: begin req_s = 1'b1; wdata_s = ocw3_fmt(bus.cmd_data); end
                        OP_RD_IRR: begin
                            req_s = 1'b1;
                            if (rd_sel_r == SEL_IRR) begin
                                is_read_s = 1'b1;
                            end else begin
                                wdata_s = OCW3_RD_IRR;
                            end
                        end
                        OP_RD_ISR: begin
                            req_s = 1'b1;
                            if (rd_sel_r == SEL_ISR) begin
                                is_read_s = 1'b1;
                            end else begin
                                wdata_s = OCW3_RD_ISR;
                            end
                        end
                        OP_RD_IMR: begin req_s = 1'b1; is_read_s = 1'b1; a0_s = 1'b1; end
                        default:   req_s = 1'b0;
                    endcase
                end else begin
                    req_s = 1'b0;
                end
            end
            ST_ICW1: begin req_s = cyc_done_s; a0_s = 1'b1; wdata_s = icw2_r; end
            ST_ICW2: begin
                a0_s = 1'b1;
                if (!sngl_r) begin
                    req_s   = cyc_done_s;
                    wdata_s = icw3_r;
                end else begin
                    req_s   = cyc_done_s && ic4_r;
                    wdata_s = icw4_r;
                end
            end
            ST_ICW3:     begin req_s = cyc_done_s && ic4_r; a0_s = 1'b1; wdata_s = icw4_r; end
            ST_PRE_OCW3: begin req_s = cyc_done_s; is_read_s = 1'b1; end
            default:     req_s = 1'b0;
        endcase
    end

    // Top sequencing FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rd_sel_r    <= SEL_IRR;
            init_done_r <= 1'b0;
            busy_r      <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= 8'h00;
            sngl_r      <= 1'b0;
            ic4_r       <= 1'b0;
            icw2_r      <= 8'h00;
            icw3_r      <= 8'h00;
            icw4_r      <= 8'h00;
            op_r        <= 3'd0;
        end else begin
            rd_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_init) begin
                        state_r     <= ST_ICW1;
                        busy_r      <= 1'b1;
                        init_done_r <= 1'b0;
                        sngl_r      <= icw1_cfg[ICW1_SNGL];
                        ic4_r       <= icw1_cfg[ICW1_IC4];
                        icw2_r      <= icw2_cfg;
                        icw3_r      <= icw3_cfg;
                        icw4_r      <= icw4_cfg;
                    end else if (accept_s) begin
                        op_r   <= bus.cmd_op;
                        busy_r <= 1'b1;
                        state_r <= ST_MAIN;
                        case (bus.cmd_op)
                            OP_OCW3: begin
                                if (bus.cmd_data[OCW3_RR]) begin
                                    rd_sel_r <= bus.cmd_data[OCW3_RIS] ? SEL_ISR : SEL_IRR;
                                end
                            end
                            OP_RD_IRR: begin
                                if (rd_sel_r != SEL_IRR) begin
                                    state_r  <= ST_PRE_OCW3;
                                    rd_sel_r <= SEL_IRR;
                                end
                            end
                            OP_RD_ISR: begin
                                if (rd_sel_r != SEL_ISR) begin
                                    state_r  <= ST_PRE_OCW3;
                                    rd_sel_r <= SEL_ISR;
                                end
                            end
                            OP_OCW1, OP_OCW2, OP_RD_IMR: state_r <= ST_MAIN;
                            default: begin
                                state_r <= ST_DONE;
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_ICW1: begin
                    if (cyc_done_s) state_r <= ST_ICW2;
                end
                ST_ICW2: begin
                    if (cyc_done_s) begin
                        if (!sngl_r) begin
                            state_r <= ST_ICW3;
                        end else if (ic4_r) begin
                            state_r <= ST_ICW4;
                        end else begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            init_done_r <= 1'b1;
                            rd_sel_r    <= SEL_IRR;
                        end
                    end
                end
                ST_ICW3: begin
                    if (cyc_done_s) begin
                        if (ic4_r) begin
                            state_r <= ST_ICW4;
                        end else begin
                            state_r     <= ST_DONE;
                            busy_r      <= 1'b0;
                            init_done_r <= 1'b1;
                            rd_sel_r    <= SEL_IRR;
                        end
                    end
                end
                ST_ICW4: begin
                    if (cyc_done_s) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        init_done_r <= 1'b1;
                        rd_sel_r    <= SEL_IRR;
                    end
                end
                ST_PRE_OCW3: begin
                    if (cyc_done_s) state_r <= ST_MAIN;
                end
                ST_MAIN: begin
                    if (cyc_done_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        if (is_read_op(op_r)) begin
                            rd_valid_r <= 1'b1;
                            rd_data_r  <= rdata_s;
                        end
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    pic_bus_cycle #(
        .T_SETUP   (T_SETUP),
        .T_STROBE  (T_STROBE),
        .T_HOLD    (T_HOLD),
        .T_RECOVER (T_RECOVER)
    ) u_cycle (
        .clk      (clk),
        .reset    (reset),
        .req      (req_s),
        .is_read  (is_read_s),
        .a0       (a0_s),
        .wdata    (wdata_s),
        .din      (bus.din),
        .done     (cyc_done_s),
        .rdata    (rdata_s),
        .bus_cs_n (bus.CS_n),
        .bus_wr_n (bus.WR_n),
        .bus_rd_n (bus.RD_n),
        .bus_a0   (bus.A0),
        .bus_dout (bus.dout),
        .bus_oe   (bus.dout_oe)
    );
endmodule

// File: doc/pic_bus_master.md
Name: pic_bus_master

Overview:
- CPU-side initiator for the 8259 programming interface. It drives CS_n/WR_n/RD_n/A0/D[7:0] into the PIC read/write logic.
- On start_init it issues the ICW1..ICW4 sequence, skipping ICW3 and ICW4 as ICW1 dictates.
- After initialization it serves a single-entry command port: OCW1/OCW2/OCW3 writes, and IRR/ISR/IMR reads.
- It tracks the PIC's read-register select so that an OCW3 is inserted only when a read needs a different select.

Parameters:
T_SETUP, 1, clocks with CS_n low and A0/data valid before the strobe
T_STROBE, 2, clocks WR_n or RD_n held low
T_HOLD, 1, clocks after strobe release with CS_n and A0/data still held
T_RECOVER, 2, clocks with CS_n high between consecutive bus cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_init  in  1  one-cycle pulse that begins the ICW sequence
icw1_cfg  in  8  ICW1 value; bit4 is forced to 1 on the bus
icw2_cfg  in  8  ICW2 value
icw3_cfg  in  8  ICW3 value, used only when icw1_cfg[1]=0
icw4_cfg  in  8  ICW4 value, used only when icw1_cfg[0]=1
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  3  0=OCW1, 1=OCW2, 2=OCW3, 3=RD_IRR, 4=RD_ISR, 5=RD_IMR; 6/7 reserved
cmd_data  in  8  payload for write ops
CS_n  out  1  chip select, active low
WR_n  out  1  write strobe, active low
RD_n  out  1  read strobe, active low
A0  out  1  address line
dout  out  8  write data
dout_oe  out  1  write-data drive enable
din  in  8  read data from the PIC
rd_data  out  8  captured read value
rd_valid  out  1  one-cycle pulse with rd_data
init_done  out  1  high after the last ICW completes
busy  out  1  high while any sequence is in progress

Behaviour:
Reset values:
- CS_n=WR_n=RD_n=1; A0=0; dout=0; dout_oe=0.
- rd_data=0; rd_valid=0; init_done=0; busy=0; cmd_ready=0.
- rd_sel (internal read-select tracker) = IRR.
- Reset asserted mid-cycle deasserts every strobe at the same edge.

Bus cycle, fixed phase order after issue:
- SETUP (T_SETUP clocks): CS_n=0, A0 valid; on writes dout_oe=1.
- STROBE (T_STROBE clocks): WR_n=0 or RD_n=0. Reads capture din into rd_data at the final STROBE clock.
- HOLD (T_HOLD clocks): strobes high; CS_n, A0 and dout held.
- RECOVER (T_RECOVER clocks): CS_n=1, dout_oe=0.
- Total cycle length is T_SETUP+T_STROBE+T_HOLD+T_RECOVER = 6 clocks at defaults.
- WR_n and RD_n are never low together.

Top FSM states: IDLE, ICW1, ICW2, ICW3, ICW4, PRE_OCW3, MAIN, DONE.

Initialization:
- start_init in IDLE sets busy=1, clears init_done and runs the ICW states in order:
  - ICW1 (A0=0, data icw1_cfg|0x10)
  - ICW2 (A0=1)
  - ICW3 (A0=1), only if icw1_cfg[1]=0
  - ICW4 (A0=1), only if icw1_cfg[0]=1
- icw*_cfg is latched at the start_init edge; later changes have no effect.
- On completion: init_done=1, busy=0, rd_sel=IRR.
- start_init while busy is ignored.
- start_init while init_done=1 re-initializes.

Commands:
- cmd_ready = init_done && state==IDLE && !start_init; start_init wins a same-cycle tie.
- cmd_op and cmd_data are latched on acceptance.
- OCW1: A0=1, data cmd_data.
- OCW2: A0=0, data {cmd_data[7:5],2'b00,cmd_data[2:0]}.
- OCW3: A0=0, data {1'b0,cmd_data[6:5],2'b01,cmd_data[2:0]}. If cmd_data[1]=1, rd_sel updates to IRR (bit0=0) or ISR (bit0=1).
- RD_IRR / RD_ISR:
  - If rd_sel already matches, issue one read cycle with A0=0.
  - Otherwise go through PRE_OCW3: write 0x0A for IRR or 0x0B for ISR, update rd_sel, then issue the read.
- RD_IMR: one read cycle with A0=1; rd_sel unchanged.
- rd_valid pulses in DONE (the clock after RECOVER ends), and busy drops in that same clock.
- Reserved ops complete in 1 clock with no bus activity and no rd_valid.

Decomposition:
- Shared package pic_pkg holds:
  - the cmd_op encoding constants;
  - OCW3 read constants 0x0A and 0x0B;
  - ICW1 bit indices IC4=0, SNGL=1, D4=4;
  - OCW bit-field positions.
- One sub-module, pic_bus_cycle:
  - inputs: req, is_read, a0, wdata; outputs: done, rdata and the pin signals;
  - contains the phase counter and takes the four timing parameters;
  - the top FSM only sequences requests into it.

Test Plan:
- Reset, then start_init with icw1=0x13, icw2=0x20, icw4=0x01 -> exactly 3 cycles are issued: ICW1 (A0=0, D=0x13), ICW2 (A0=1, D=0x20), ICW4 (A0=1, D=0x01). ICW3 is skipped, and init_done rises 18 clocks after start.
- icw1=0x10, icw3=0x04 -> the sequence is ICW1 (D=0x10), ICW2, ICW3 (A0=1, D=0x04), with no ICW4.
- After init, RD_IRR with din=0x5A -> a single read cycle (A0=0) with no OCW3; rd_data=0x5A and rd_valid pulses once.
- RD_ISR, then RD_ISR again -> the first does an OCW3 write of 0x0B and then a read; the second reads only. A following RD_IRR writes 0x0A first.
- OCW2 with cmd_data=0xFF -> D=0xE7, A0=0. OCW1 with 0xA5 -> D=0xA5, A0=1. RD_IMR -> A0=1 read, with no OCW3.
- Reset asserted during the STROBE phase of ICW2 -> WR_n=1 and CS_n=1 at that edge, init_done=0 and cmd_ready=0; a new start_init restarts from ICW1.
